// File: rtl/fcpu_pkg.sv
// Shared types and default widths for the fcpu CRAM read path.
// Holds the read-arbiter FSM state encoding and the default AXI widths.
// The grant-selection helper is here too so its policy lives in one place.
package fcpu_pkg;

   localparam int ID_W_DEF    = 4;
   localparam int ADDR_W_DEF  = 32;
   localparam int RDATA_W_DEF = 32;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_ADDR = 2'd1,
      ARB_DATA = 2'd2
   } arb_state_t;

   // Returns the slave to grant: 0 = core (s0), 1 = mmu (s1).
   // On a tie the slave that did not win last time gets the grant.
   function automatic logic pick_grant(input logic req0, input logic req1,
                                       input logic last_grant);
      if (req0 && req1) return ~last_grant;
      return req1;
   endfunction

endpackage

// File: rtl/cram_read_arbiter.sv
// Purpose : arbitrates AXI read requests from core (s0) and mmu (s1) onto one CRAM read master.
// Latency : grant->m_arvalid 1 cycle; m_r*->sN_r* combinational; last R beat->next grant 1 cycle.
// Backpressure: one transaction in flight; sN_arready low outside IDLE; m_rready follows the granted sN_rready.
// Ports   : clk/nrst; s0_*, s1_* AXI AR+R slave ports; m_* AXI AR+R master port; err_rlast sticky flag.
module cram_read_arbiter
   import fcpu_pkg::*;
#(
   parameter int ID_W    = ID_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int RDATA_W = RDATA_W_DEF
) (
   input  logic               clk,
   input  logic               nrst,
   // s0 = core
   input  logic [ID_W-1:0]    s0_arid,
   input  logic [ADDR_W-1:0]  s0_araddr,
   input  logic [7:0]         s0_arlen,
   input  logic [2:0]         s0_arsize,
   input  logic [1:0]         s0_arburst,
   input  logic               s0_arlock,
   input  logic [3:0]         s0_arcache,
   input  logic [2:0]         s0_arprot,
   input  logic [3:0]         s0_arqos,
   input  logic               s0_arvalid,
   output logic               s0_arready,
   output logic [ID_W-1:0]    s0_rid,
   output logic [RDATA_W-1:0] s0_rdata,
   output logic [1:0]         s0_rresp,
   output logic               s0_rlast,
   output logic               s0_rvalid,
   input  logic               s0_rready,
   // s1 = mmu
   input  logic [ID_W-1:0]    s1_arid,
   input  logic [ADDR_W-1:0]  s1_araddr,
   input  logic [7:0]         s1_arlen,
   input  logic [2:0]         s1_arsize,
   input  logic [1:0]         s1_arburst,
   input  logic               s1_arlock,
   input  logic [3:0]         s1_arcache,
   input  logic [2:0]         s1_arprot,
   input  logic [3:0]         s1_arqos,
   input  logic               s1_arvalid,
   output logic               s1_arready,
   output logic [ID_W-1:0]    s1_rid,
   output logic [RDATA_W-1:0] s1_rdata,
   output logic [1:0]         s1_rresp,
   output logic               s1_rlast,
   output logic               s1_rvalid,
   input  logic               s1_rready,
   // master toward CRAM
   output logic [ID_W-1:0]    m_arid,
   output logic [ADDR_W-1:0]  m_araddr,
   output logic [7:0]         m_arlen,
   output logic [2:0]         m_arsize,
   output logic [1:0]         m_arburst,
   output logic               m_arlock,
   output logic [3:0]         m_arcache,
   output logic [2:0]         m_arprot,
   output logic [3:0]         m_arqos,
   output logic               m_arvalid,
   input  logic               m_arready,
   input  logic [ID_W-1:0]    m_rid,
   input  logic [RDATA_W-1:0] m_rdata,
   input  logic [1:0]         m_rresp,
   input  logic               m_rlast,
   input  logic               m_rvalid,
   output logic               m_rready,
   output logic               err_rlast
);

   arb_state_t state, state_nxt;

   logic              grant_idx;   // 0 = s0, 1 = s1
   logic              last_grant;
   logic [7:0]        beat_cnt;
   logic [7:0]        len_stored;
   logic [ID_W-1:0]   ar_id;
   logic [ADDR_W-1:0] ar_addr;
   logic [7:0]        ar_len;
   logic [2:0]        ar_size;
   logic [1:0]        ar_burst;
   logic              ar_lock;
   logic [3:0]        ar_cache;
   logic [2:0]        ar_prot;
   logic [3:0]        ar_qos;

   logic any_req;
   logic grant_sel;
   logic beat;

   assign any_req   = s0_arvalid | s1_arvalid;
   assign grant_sel = pick_grant(s0_arvalid, s1_arvalid, last_grant);
   assign beat      = (state == ARB_DATA) && m_rvalid && m_rready;

   // state register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state <= ARB_IDLE;
      else       state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ARB_IDLE: if (any_req)           state_nxt = ARB_ADDR;
         ARB_ADDR: if (m_arready)         state_nxt = ARB_DATA;
         ARB_DATA: if (beat && m_rlast)   state_nxt = ARB_IDLE;
         default:                         state_nxt = ARB_IDLE;
      endcase
   end

   // outputs: AR side from the latched payload, R side routed by grant_idx only
   always_comb begin
      s0_arready = 1'b0;
      s1_arready = 1'b0;
      m_arvalid  = 1'b0;
      m_rready   = 1'b0;
      s0_rvalid  = 1'b0;
      s0_rid     = '0;
      s0_rdata   = '0;
      s0_rresp   = '0;
      s0_rlast   = 1'b0;
      s1_rvalid  = 1'b0;
      s1_rid     = '0;
      s1_rdata   = '0;
      s1_rresp   = '0;
      s1_rlast   = 1'b0;
      case (state)
         ARB_IDLE: begin
            s0_arready = any_req && !grant_sel;
            s1_arready = any_req &&  grant_sel;
         end
         ARB_ADDR: m_arvalid = 1'b1;
         ARB_DATA: begin
            if (grant_idx) begin
               m_rready  = s1_rready;
               s1_rvalid = m_rvalid;
               s1_rid    = m_rid;
               s1_rdata  = m_rdata;
               s1_rresp  = m_rresp;
               s1_rlast  = m_rlast;
            end else begin
               m_rready  = s0_rready;
               s0_rvalid = m_rvalid;
               s0_rid    = m_rid;
               s0_rdata  = m_rdata;
               s0_rresp  = m_rresp;
               s0_rlast  = m_rlast;
            end
         end
         default: ;
      endcase
   end

   assign m_arid    = ar_id;
   assign m_araddr  = ar_addr;
   assign m_arlen   = ar_len;
   assign m_arsize  = ar_size;
   assign m_arburst = ar_burst;
   assign m_arlock  = ar_lock;
   assign m_arcache = ar_cache;
   assign m_arprot  = ar_prot;
   assign m_arqos   = ar_qos;

   // payload latch, beat counter, rlast checking
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         grant_idx  <= 1'b0;
         last_grant <= 1'b1;   // s0 wins the first tie after reset
         beat_cnt   <= '0;
         len_stored <= '0;
         ar_id      <= '0;
         ar_addr    <= '0;
         ar_len     <= '0;
         ar_size    <= '0;
         ar_burst   <= '0;
         ar_lock    <= 1'b0;
         ar_cache   <= '0;
         ar_prot    <= '0;
         ar_qos     <= '0;
         err_rlast  <= 1'b0;
      end else begin
         if (state == ARB_IDLE && any_req) begin
            grant_idx  <= grant_sel;
            last_grant <= grant_sel;
            ar_id      <= grant_sel ? s1_arid    : s0_arid;
            ar_addr    <= grant_sel ? s1_araddr  : s0_araddr;
            ar_len     <= grant_sel ? s1_arlen   : s0_arlen;
            ar_size    <= grant_sel ? s1_arsize  : s0_arsize;
            ar_burst   <= grant_sel ? s1_arburst : s0_arburst;
            ar_lock    <= grant_sel ? s1_arlock  : s0_arlock;
            ar_cache   <= grant_sel ? s1_arcache : s0_arcache;
            ar_prot    <= grant_sel ? s1_arprot  : s0_arprot;
            ar_qos     <= grant_sel ? s1_arqos   : s0_arqos;
         end
         if (state == ARB_ADDR && m_arready) begin
            beat_cnt   <= '0;
            len_stored <= ar_len;
         end
         if (beat) begin
            // counter saturates so an overlong burst cannot wrap back to a "valid" index
            if (beat_cnt != 8'hFF) beat_cnt <= beat_cnt + 8'd1;
            if (m_rlast != (beat_cnt == len_stored)) err_rlast <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cram_read_arbiter.sv
// Directed bench for cram_read_arbiter: grant, round-robin, AR stall, R backpressure,
// rlast error and mid-burst reset, each against hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_cram_read_arbiter;

   localparam int ID_W = 4;
   localparam int ADDR_W = 32;
   localparam int RDATA_W = 32;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   logic [ID_W-1:0] s0_arid = '0, s1_arid = '0, s0_rid, s1_rid, m_arid, m_rid = '0;
   logic [ADDR_W-1:0] s0_araddr = '0, s1_araddr = '0, m_araddr;
   logic [7:0] s0_arlen = '0, s1_arlen = '0, m_arlen;
   logic [2:0] s0_arsize = 3'd2, s1_arsize = 3'd2, m_arsize;
   logic [1:0] s0_arburst = 2'b01, s1_arburst = 2'b01, m_arburst;
   logic s0_arlock = 1'b0, s1_arlock = 1'b0, m_arlock;
   logic [3:0] s0_arcache = '0, s1_arcache = '0, m_arcache;
   logic [2:0] s0_arprot = '0, s1_arprot = '0, m_arprot;
   logic [3:0] s0_arqos = '0, s1_arqos = '0, m_arqos;
   logic s0_arvalid = 1'b0, s1_arvalid = 1'b0, s0_arready, s1_arready;
   logic [RDATA_W-1:0] s0_rdata, s1_rdata, m_rdata = '0;
   logic [1:0] s0_rresp, s1_rresp, m_rresp = '0;
   logic s0_rlast, s1_rlast, m_rlast = 1'b0;
   logic s0_rvalid, s1_rvalid, m_rvalid = 1'b0;
   logic s0_rready = 1'b1, s1_rready = 1'b1, m_rready;
   logic m_arvalid, m_arready = 1'b0;
   logic err_rlast;

   int checks = 0;
   int errors = 0;

   cram_read_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .RDATA_W(RDATA_W)) dut (
      .clk(clk), .nrst(nrst),
      .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
      .s0_arburst(s0_arburst), .s0_arlock(s0_arlock), .s0_arcache(s0_arcache),
      .s0_arprot(s0_arprot), .s0_arqos(s0_arqos), .s0_arvalid(s0_arvalid),
      .s0_arready(s0_arready), .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
      .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
      .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
      .s1_arburst(s1_arburst), .s1_arlock(s1_arlock), .s1_arcache(s1_arcache),
      .s1_arprot(s1_arprot), .s1_arqos(s1_arqos), .s1_arvalid(s1_arvalid),
      .s1_arready(s1_arready), .s1_rid(s1_rid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
      .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
      .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache),
      .m_arprot(m_arprot), .m_arqos(m_arqos), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .err_rlast(err_rlast)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // From ADDR: accept the AR in one cycle, leaving the DUT in DATA.
   task automatic addr_phase();
      m_arready = 1'b1;
      tick();
      m_arready = 1'b0;
   endtask

   // Full burst to slave `who` with no backpressure; leaves the DUT in IDLE.
   task automatic burst(input int who, input int nbeats, input logic [31:0] base);
      for (int i = 0; i < nbeats; i++) begin
         m_rvalid = 1'b1;
         m_rid    = 4'hA;
         m_rdata  = base + 32'(i);
         m_rlast  = (i == nbeats - 1);
         #1;
         if (who == 0) begin
            chk("s0_rvalid", s0_rvalid, 1);
            chk("s0_rdata", s0_rdata, base + 32'(i));
            chk("s0_rid", s0_rid, 4'hA);
            chk("s1_rvalid_idle", s1_rvalid, 0);
            chk("s1_rdata_zero", s1_rdata, 0);
         end else begin
            chk("s1_rvalid", s1_rvalid, 1);
            chk("s1_rdata", s1_rdata, base + 32'(i));
            chk("s1_rid", s1_rid, 4'hA);
            chk("s0_rvalid_idle", s0_rvalid, 0);
            chk("s0_rdata_zero", s0_rdata, 0);
         end
         tick();
      end
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      #1;
      nrst = 1'b1;
      tick();
   endtask

   initial begin
      int nb;
      // reset state
      #3;
      chk("rst_m_arvalid", m_arvalid, 0);
      chk("rst_m_rready", m_rready, 0);
      chk("rst_s0_arready", s0_arready, 0);
      chk("rst_err", err_rlast, 0);
      chk("rst_m_araddr", m_araddr, 0);
      tick();
      nrst = 1'b1;
      tick();

      // s0 alone, addr 0x100, 4 beats
      s0_arvalid = 1'b1; s0_araddr = 32'h100; s0_arlen = 8'd3; s0_arid = 4'h5;
      #1;
      chk("t1_s0_arready", s0_arready, 1);
      chk("t1_s1_arready", s1_arready, 0);
      tick();
      s0_arvalid = 1'b0;
      #1;
      chk("t1_m_arvalid", m_arvalid, 1);
      chk("t1_m_araddr", m_araddr, 32'h100);
      chk("t1_m_arid", m_arid, 4'h5);
      chk("t1_m_arlen", m_arlen, 8'd3);
      chk("t1_s0_arready_addr", s0_arready, 0);
      addr_phase();
      burst(0, 4, 32'hA0);
      #1;
      chk("t1_err", err_rlast, 0);
      chk("t1_m_rready_idle", m_rready, 0);

      // round robin after reset
      do_reset();
      s0_arvalid = 1'b1; s0_araddr = 32'h200; s0_arlen = 8'd1;
      s1_arvalid = 1'b1; s1_araddr = 32'h300; s1_arlen = 8'd1;
      #1;
      chk("rr1_s0_arready", s0_arready, 1);
      chk("rr1_s1_arready", s1_arready, 0);
      tick();
      #1;
      chk("rr1_m_araddr", m_araddr, 32'h200);
      chk("rr1_s1_wait", s1_arready, 0);
      addr_phase();
      burst(0, 2, 32'h20);
      #1;
      chk("rr2_s1_arready", s1_arready, 1);
      chk("rr2_s0_arready", s0_arready, 0);
      tick();
      #1;
      chk("rr2_m_araddr", m_araddr, 32'h300);
      addr_phase();
      burst(1, 2, 32'h30);
      #1;
      chk("rr3_s0_arready", s0_arready, 1);
      chk("rr3_s1_arready", s1_arready, 0);
      tick();
      s0_arvalid = 1'b0; s1_arvalid = 1'b0;

      // AR stall: m_arready low for 5 cycles
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("stall_m_arvalid", m_arvalid, 1);
         chk("stall_m_araddr", m_araddr, 32'h200);
         chk("stall_s0_arready", s0_arready, 0);
         chk("stall_s1_arready", s1_arready, 0);
         tick();
      end
      addr_phase();
      burst(0, 2, 32'h40);

      // s1 burst with toggling rready
      s1_arvalid = 1'b1; s1_araddr = 32'h400; s1_arlen = 8'd3;
      #1;
      chk("bp_s1_arready", s1_arready, 1);
      tick();
      s1_arvalid = 1'b0;
      addr_phase();
      nb = 0;
      for (int cyc = 0; cyc < 20 && nb < 4; cyc++) begin
         s1_rready = (cyc % 2 == 0);
         m_rvalid = 1'b1;
         m_rdata = 32'hB0 + 32'(nb);
         m_rlast = (nb == 3);
         #1;
         chk("bp_m_rready", m_rready, s1_rready);
         chk("bp_s1_rvalid", s1_rvalid, 1);
         chk("bp_s1_rdata", s1_rdata, 32'hB0 + 32'(nb));
         chk("bp_s0_rvalid", s0_rvalid, 0);
         if (s1_rready) nb++;
         tick();
      end
      m_rvalid = 1'b0; m_rlast = 1'b0; s1_rready = 1'b1;
      chk("bp_beats", nb, 4);
      #1;
      chk("bp_idle_m_rready", m_rready, 0);
      chk("bp_err", err_rlast, 0);

      // early rlast -> sticky error
      s0_arvalid = 1'b1; s0_araddr = 32'h500; s0_arlen = 8'd1;
      tick();
      s0_arvalid = 1'b0;
      addr_phase();
      burst(0, 1, 32'hC0);
      #1;
      chk("err_set", err_rlast, 1);
      chk("err_idle_m_rready", m_rready, 0);
      s1_arvalid = 1'b1; s1_araddr = 32'h580; s1_arlen = 8'd0;
      #1;
      chk("err_idle_grant", s1_arready, 1);
      tick();
      s1_arvalid = 1'b0;
      addr_phase();
      burst(1, 1, 32'hC8);
      #1;
      chk("err_sticky", err_rlast, 1);
      nrst = 1'b0;
      #1;
      chk("err_cleared", err_rlast, 0);
      nrst = 1'b1;
      tick();

      // reset during beat 2 of 4
      s1_arvalid = 1'b1; s1_araddr = 32'h600; s1_arlen = 8'd3;
      tick();
      s1_arvalid = 1'b0;
      addr_phase();
      for (int i = 0; i < 2; i++) begin
         m_rvalid = 1'b1; m_rdata = 32'hD0 + 32'(i); m_rlast = 1'b0;
         tick();
      end
      m_rdata = 32'hD2;
      #1;
      chk("mr_s1_rvalid_pre", s1_rvalid, 1);
      nrst = 1'b0;
      #1;
      chk("mr_s1_rvalid", s1_rvalid, 0);
      chk("mr_s1_rdata", s1_rdata, 0);
      chk("mr_m_rready", m_rready, 0);
      chk("mr_m_arvalid", m_arvalid, 0);
      chk("mr_m_araddr", m_araddr, 0);
      chk("mr_err", err_rlast, 0);
      m_rvalid = 1'b0;
      tick();
      nrst = 1'b1;
      s1_arvalid = 1'b1; s1_araddr = 32'h700; s1_arlen = 8'd0;
      #1;
      chk("mr_regrant", s1_arready, 1);
      tick();
      s1_arvalid = 1'b0;
      #1;
      chk("mr_m_arvalid2", m_arvalid, 1);
      chk("mr_m_araddr2", m_araddr, 32'h700);
      addr_phase();
      burst(1, 1, 32'hE0);
      #1;
      chk("mr_err_after", err_rlast, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/cram_read_arbiter.md
CRAM_READ_ARBITER -- requirements
Module: cram_read_arbiter

Interface
REQ-001 SHALL take parameter ID_W, default 4, meaning AXI ID width on all ports.
REQ-002 SHALL take parameter ADDR_W, default 32, meaning AXI read address width.
REQ-003 SHALL take parameter RDATA_W, default 32, meaning AXI read data width.
REQ-004 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port nrst  in  1  reset; the block has one clock, and reset is asynchronous and active-low.
REQ-006 SHALL have, for each slave port sN in {s0 = core, s1 = mmu}, ports sN_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos  in  ID_W/ADDR_W/8/3/2/1/4/3/4  read-address payload.
REQ-007 SHALL have ports sN_arvalid in 1 and sN_arready out 1  AR handshake per slave.
REQ-008 SHALL have ports sN_rid/rdata/rresp/rlast  out  ID_W/RDATA_W/2/1  read-data payload per slave.
REQ-009 SHALL have ports sN_rvalid out 1 and sN_rready in 1  R handshake per slave.
REQ-010 SHALL have ports m_arid..m_arqos out and m_arvalid out 1 / m_arready in 1  AR master toward CRAM, with the same widths as REQ-006.
REQ-011 SHALL have ports m_rid/rdata/rresp/rlast/rvalid in and m_rready out  R master from CRAM.
REQ-012 SHALL have port err_rlast  out  1  sticky protocol-error flag.

Function
REQ-013 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE, with exactly one outstanding transaction.
REQ-014 IDLE: SHALL grant when any sN_arvalid=1; assert granted sN_arready combinationally that cycle only; latch the full AR payload and grant index; next state ADDR.
REQ-015 Simultaneous s0/s1 arvalid: SHALL grant the slave not granted last (round-robin); last-grant pointer resets so s0 wins the first contest.
REQ-016 ADDR: SHALL drive m_arvalid=1 from the latched payload (stable until handshake); on m_arready=1 go to DATA, clear the beat counter, store arlen.
REQ-017 DATA: SHALL route granted sN_rvalid=m_rvalid, sN_r* payload=m_r*, m_rready=granted sN_rready; the ungranted slave sees rvalid=0.
REQ-018 DATA: beat counter (8-bit) SHALL increment on each m_rvalid&m_rready; on the beat with m_rlast=1, go to IDLE.
REQ-019 SHALL set err_rlast when m_rlast arrives with counter != stored arlen, or when counter == arlen without m_rlast (counter saturates; FSM still exits only on rlast).
REQ-020 sN_arready SHALL be 0 in ADDR and DATA; a request arriving then waits, with arvalid held by the slave.
REQ-021 Latency: grant→m_arvalid 1 cycle; m_rvalid→sN_rvalid 0 cycles (combinational path); last R beat→next grant 1 cycle.
REQ-022 SHALL pass IDs unmodified; R routing uses only the latched grant index.
REQ-023 sN_r* payload outputs SHALL be 0 when that slave is not granted in DATA.

Reset
REQ-024 SHALL, on nrst=0, immediately set: state IDLE, m_arvalid=0, m_rready=0, sN_arready=0, sN_rvalid=0, err_rlast=0, latched payload=0, counter=0, last-grant pointer=s1.
REQ-025 Reset mid-transaction SHALL abandon the burst without error; remaining CRAM beats after release are ignored only if the CRAM is also reset (system requirement).
REQ-026 err_rlast SHALL clear only on reset.

Structure
REQ-027 The FSM state enum (ARB_IDLE/ARB_ADDR/ARB_DATA) and the default widths SHALL live in fcpu_pkg.
REQ-028 SHALL be a single module, with no sub-modules; it replaces the vendor interconnect between core/mmu and CRAM in fcpu.

Verification
REQ-029 s0 only, araddr=0x100, arlen=3 → s0_arready 1 cycle, m_araddr=0x100 next cycle, 4 beats delivered to s0, s1_rvalid=0 throughout.
REQ-030 s0 and s1 asserted same cycle after reset → s0 granted first, s1 granted 1 cycle after s0's rlast; second contest → s1 first.
REQ-031 m_arready held 0 for 5 cycles → m_araddr/m_arvalid stable for all 5 cycles; no sN_arready pulses.
REQ-032 s1_rready toggling 1/0 during a 4-beat burst → m_rready mirrors it, no beat lost or duplicated.
REQ-033 arlen=1, CRAM asserts rlast on beat 0 → err_rlast=1 and FSM returns to IDLE; err_rlast stays 1 until nrst.
REQ-034 nrst asserted during beat 2 of 4 → all outputs 0 asynchronously; after release, s1 request granted normally.
